// File: rtl/freelist_ckpt.sv
// freelist_ckpt: multi-port tag freelist with branch checkpoints for rename/dispatch.
// Grants up to ALLOC_W lowest-index free tags per cycle with 0-cycle latency, takes up to
// REL_W releases per cycle, and restores every tag allocated after a checkpoint in one cycle.
// Grants are all-or-nothing: suppressed by stall, prmiss, reset or too few free tags.
// Ports: clk/reset (sync, active-high); req_valid/stall -> alloc_tag/alloc_valid/allocatable;
//   free_count (registered); rel_tag/rel_valid; ckpt_take/ckpt_id/ckpt_free; prmiss/prmiss_ckpt.
// Optional macro FREELIST_REL_BYPASS_EN: tags released this cycle are grantable this cycle.
module freelist_ckpt #(
  parameter int FREE_NUM = 64,
  parameter int FREE_SEL = 6,
  parameter int ALLOC_W  = 2,
  parameter int REL_W    = 3,
  parameter int CKPT_NUM = 4,
  parameter int CKPT_SEL = 2,
  parameter int RESV_NUM = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ALLOC_W-1:0]          req_valid,
  input  logic                        stall,
  output logic [ALLOC_W*FREE_SEL-1:0] alloc_tag,
  output logic [ALLOC_W-1:0]          alloc_valid,
  output logic                        allocatable,
  output logic [FREE_SEL:0]           free_count,
  input  logic [REL_W*FREE_SEL-1:0]   rel_tag,
  input  logic [REL_W-1:0]            rel_valid,
  input  logic                        ckpt_take,
  input  logic [CKPT_SEL-1:0]         ckpt_id,
  input  logic [CKPT_NUM-1:0]         ckpt_free,
  input  logic                        prmiss,
  input  logic [CKPT_SEL-1:0]         prmiss_ckpt
);

  localparam int CW = FREE_SEL + 1;
  // one extra bit so free_count + releases cannot wrap in the bypass comparison
  localparam int AW = FREE_SEL + 2;
  localparam logic [FREE_NUM-1:0] RESET_FREE = {FREE_NUM{1'b1}} << RESV_NUM;

  logic [FREE_NUM-1:0] free_bits;
  logic [CKPT_NUM-1:0] ckpt_valid;
  logic [FREE_NUM-1:0] alloc_mask [CKPT_NUM];

  logic [FREE_NUM-1:0] released, granted, search, free_nxt;
  logic [AW-1:0]       req_cnt, rel_cnt, grant_cnt;
  logic [CW-1:0]       count_nxt;
  logic                go, recover;

  function automatic logic [CW-1:0] popcnt(input logic [FREE_NUM-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < FREE_NUM; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // one-hot decode of all release ports into a single vector
  always_comb begin
    released = '0;
    rel_cnt  = '0;
    req_cnt  = '0;
    for (int p = 0; p < REL_W; p++) begin
      rel_cnt = rel_cnt + AW'(rel_valid[p]);
      for (int t = 0; t < FREE_NUM; t++)
        if (rel_valid[p] && rel_tag[p*FREE_SEL +: FREE_SEL] == FREE_SEL'(t))
          released[t] = 1'b1;
    end
    for (int j = 0; j < ALLOC_W; j++) req_cnt = req_cnt + AW'(req_valid[j]);
  end

`ifdef FREELIST_REL_BYPASS_EN
  assign search      = free_bits | released;
  assign allocatable = ({1'b0, free_count} + rel_cnt) >= req_cnt;
`else
  assign search      = free_bits;
  assign allocatable = {1'b0, free_count} >= req_cnt;
`endif

  assign go      = ~stall & ~prmiss & allocatable & ~reset;
  assign recover = prmiss & ckpt_valid[prmiss_ckpt];

  // Priority pick: each requesting port, in port order, takes the lowest tag
  // still available after earlier ports. allocatable guarantees a hit.
  always_comb begin
    logic [FREE_NUM-1:0] avail;
    logic                found;
    avail       = search;
    granted     = '0;
    alloc_valid = '0;
    alloc_tag   = '0;
    grant_cnt   = '0;
    found       = 1'b0;
    for (int j = 0; j < ALLOC_W; j++) begin
      found = 1'b0;
      if (go && req_valid[j]) begin
        for (int t = 0; t < FREE_NUM; t++) begin
          if (!found && avail[t]) begin
            found                             = 1'b1;
            avail[t]                          = 1'b0;
            granted[t]                        = 1'b1;
            alloc_valid[j]                    = 1'b1;
            alloc_tag[j*FREE_SEL +: FREE_SEL] = FREE_SEL'(t);
          end
        end
      end
      grant_cnt = grant_cnt + AW'(alloc_valid[j]);
    end
  end

  // Recovery rebuilds the count from the vector; grants are impossible then
  // because prmiss gates go.
  always_comb begin
    if (recover) begin
      free_nxt  = free_bits | released | alloc_mask[prmiss_ckpt];
      count_nxt = popcnt(free_nxt);
    end else begin
      free_nxt  = (free_bits | released) & ~granted;
      count_nxt = CW'({1'b0, free_count} + rel_cnt - grant_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      free_bits  <= RESET_FREE;
      free_count <= CW'(FREE_NUM - RESV_NUM);
      ckpt_valid <= '0;
      for (int s = 0; s < CKPT_NUM; s++) alloc_mask[s] <= '0;
    end else begin
      free_bits  <= free_nxt;
      free_count <= count_nxt;
      for (int s = 0; s < CKPT_NUM; s++) begin
        if (ckpt_take && ckpt_id == CKPT_SEL'(s)) begin
          // same-cycle grants are younger than the branch: start empty
          ckpt_valid[s] <= 1'b1;
          alloc_mask[s] <= '0;
        end else if (ckpt_free[s] || (recover && prmiss_ckpt == CKPT_SEL'(s))) begin
          ckpt_valid[s] <= 1'b0;
          alloc_mask[s] <= '0;
        end else if (ckpt_valid[s]) begin
          alloc_mask[s] <= alloc_mask[s] | granted;
        end
      end
    end
  end

endmodule

// File: tb/tb_freelist_ckpt.sv
// tb_freelist_ckpt: scoreboard bench for freelist_ckpt (default parameters).
// Each cycle the expected grant/count is pushed when stimulus is driven and
// popped/compared mid-cycle; directed checks pin the key values to constants.
module tb_freelist_ckpt;
  localparam int FN = 64, FS = 6, AWD = 2, RW = 3, CN = 4, CS = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [AWD-1:0]    req_valid;
  logic              stall;
  logic [AWD*FS-1:0] alloc_tag;
  logic [AWD-1:0]    alloc_valid;
  logic              allocatable;
  logic [FS:0]       free_count;
  logic [RW*FS-1:0]  rel_tag;
  logic [RW-1:0]     rel_valid;
  logic              ckpt_take;
  logic [CS-1:0]     ckpt_id;
  logic [CN-1:0]     ckpt_free;
  logic              prmiss;
  logic [CS-1:0]     prmiss_ckpt;

  always #5 clk = ~clk;

  freelist_ckpt #(.FREE_NUM(FN), .FREE_SEL(FS), .ALLOC_W(AWD), .REL_W(RW),
                  .CKPT_NUM(CN), .CKPT_SEL(CS), .RESV_NUM(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .stall(stall),
    .alloc_tag(alloc_tag), .alloc_valid(alloc_valid), .allocatable(allocatable),
    .free_count(free_count), .rel_tag(rel_tag), .rel_valid(rel_valid),
    .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_free(ckpt_free),
    .prmiss(prmiss), .prmiss_ckpt(prmiss_ckpt));

  typedef struct {
    int av;
    int tag0;
    int tag1;
    int alc;
    int cnt;
  } exp_t;
  exp_t sbq[$];

  int n_pass = 0, n_total = 0;

  // reference model state
  bit m_free [FN];
  int m_cnt;
  bit m_cv   [CN];
  bit m_mask [CN][FN];

  // DUT values observed in the last step, for directed checks against constants
  int obs_av, obs_tag0, obs_tag1, obs_alc, obs_cnt;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic set_idle();
    req_valid = '0; stall = 1'b0; rel_tag = '0; rel_valid = '0;
    ckpt_take = 1'b0; ckpt_id = '0; ckpt_free = '0; prmiss = 1'b0; prmiss_ckpt = '0;
  endtask

  task automatic rel(input int port, input int tag);
    rel_valid[port]          = 1'b1;
    rel_tag[port*FS +: FS]   = tag[FS-1:0];
  endtask

  // One cycle: inputs already driven (1 time unit after posedge).
  task automatic step();
    exp_t e;
    exp_t got;
    bit   rl    [FN];
    bit   avail [FN];
    bit   gr    [FN];
    int   nrel, nreq, ngr, t, pc;
    bit   go, found, rec;
    nrel = 0; ngr = 0;
    for (int i = 0; i < FN; i++) begin rl[i] = 0; gr[i] = 0; end
    for (int p = 0; p < RW; p++) begin
      if (rel_valid[p]) begin
        t = int'(rel_tag[p*FS +: FS]);
        assert (!m_free[t] && !rl[t]) else $error("illegal release of tag %0d", t);
        rl[t] = 1; nrel++;
      end
    end
    pc = int'(prmiss_ckpt);
    if (prmiss) assert (m_cv[pc]) else $error("prmiss to invalid slot %0d", pc);
    nreq = int'(req_valid[0]) + int'(req_valid[1]);
`ifdef FREELIST_REL_BYPASS_EN
    e.alc = ((m_cnt + nrel) >= nreq) ? 1 : 0;
    for (int i = 0; i < FN; i++) avail[i] = m_free[i] | rl[i];
`else
    e.alc = (m_cnt >= nreq) ? 1 : 0;
    for (int i = 0; i < FN; i++) avail[i] = m_free[i];
`endif
    go = !stall && !prmiss && (e.alc == 1);
    e.av = 0; e.tag0 = -1; e.tag1 = -1; e.cnt = m_cnt;
    for (int j = 0; j < AWD; j++) begin
      found = 0;
      if (go && req_valid[j]) begin
        for (int i = 0; i < FN; i++) begin
          if (!found && avail[i]) begin
            found = 1; avail[i] = 0; gr[i] = 1; ngr++;
            e.av = e.av | (1 << j);
            if (j == 0) e.tag0 = i; else e.tag1 = i;
          end
        end
      end
    end
    sbq.push_back(e);

    #3;
    got = sbq.pop_front();
    obs_av = int'(alloc_valid); obs_tag0 = int'(alloc_tag[FS-1:0]);
    obs_tag1 = int'(alloc_tag[2*FS-1:FS]); obs_alc = int'(allocatable);
    obs_cnt = int'(free_count);
    check("alloc_valid", obs_av, got.av);
    if (got.av[0]) check("alloc_tag0", obs_tag0, got.tag0);
    if (got.av[1]) check("alloc_tag1", obs_tag1, got.tag1);
    check("allocatable", obs_alc, got.alc);
    check("free_count", obs_cnt, got.cnt);

    @(posedge clk);
    rec = prmiss && m_cv[pc];
    if (rec) begin
      m_cnt = 0;
      for (int i = 0; i < FN; i++) begin
        m_free[i] = m_free[i] | rl[i] | m_mask[pc][i];
        m_cnt += int'(m_free[i]);
      end
    end else begin
      for (int i = 0; i < FN; i++) m_free[i] = (m_free[i] | rl[i]) & !gr[i];
      m_cnt = m_cnt + nrel - ngr;
    end
    for (int s = 0; s < CN; s++) begin
      if (ckpt_take && int'(ckpt_id) == s) begin
        m_cv[s] = 1;
        for (int i = 0; i < FN; i++) m_mask[s][i] = 0;
      end else if (ckpt_free[s] || (rec && pc == s)) begin
        m_cv[s] = 0;
        for (int i = 0; i < FN; i++) m_mask[s][i] = 0;
      end else if (m_cv[s]) begin
        for (int i = 0; i < FN; i++) m_mask[s][i] = m_mask[s][i] | gr[i];
      end
    end
    #1;
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    set_idle();
    reset = 1'b1;
    req_valid = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_alloc_valid", int'(alloc_valid), 0);
    check("rst_free_count", int'(free_count), 64);
    reset = 1'b0;
    for (int i = 0; i < FN; i++) m_free[i] = 1;
    m_cnt = FN;
    for (int s = 0; s < CN; s++) begin
      m_cv[s] = 0;
      for (int i = 0; i < FN; i++) m_mask[s][i] = 0;
    end

    // first grants after reset: lowest two tags, then the next two
    req_valid = 2'b11; step();
    check("p1_valid", obs_av, 3); check("p1_tag0", obs_tag0, 0); check("p1_tag1", obs_tag1, 1);
    req_valid = 2'b11; step();
    check("p1_cnt", obs_cnt, 62); check("p1b_tag0", obs_tag0, 2); check("p1b_tag1", obs_tag1, 3);

    // only the upper port requests
    req_valid = 2'b10; step();
    check("p2_valid", obs_av, 2); check("p2_tag1", obs_tag1, 4); check("p2_cnt", obs_cnt, 60);

    // drain down to one free tag
    for (int k = 0; k < 40 && m_cnt > 1; k++) begin
      req_valid = 2'b11; step();
    end
    req_valid = 2'b11; step();
    check("one_left_valid", obs_av, 0); check("one_left_alc", obs_alc, 0);
    check("one_left_cnt", obs_cnt, 1);
    req_valid = 2'b01; step();
    check("last_tag", obs_tag0, 63);
    req_valid = 2'b00; step();
    check("empty_noreq_alc", obs_alc, 1); check("empty_cnt", obs_cnt, 0);
    req_valid = 2'b01; step();
    check("empty_req_alc", obs_alc, 0);

    // release-to-reuse latency on an empty list
    req_valid = 2'b01; rel(0, 5); step();
`ifdef FREELIST_REL_BYPASS_EN
    check("bypass_same_valid", obs_av, 1); check("bypass_same_tag", obs_tag0, 5);
`else
    check("rel_same_valid", obs_av, 0);
`endif
    req_valid = 2'b01; step();
`ifdef FREELIST_REL_BYPASS_EN
    check("bypass_next_valid", obs_av, 0);
`else
    check("rel_next_valid", obs_av, 1); check("rel_next_tag", obs_tag0, 5);
`endif

    // checkpoint recovery of 10,11,12
    rel(0, 10); rel(1, 11); rel(2, 12); step();
    rel(0, 20); rel(1, 21); rel(2, 22); step();
    ckpt_take = 1'b1; ckpt_id = 2'd1; step();
    req_valid = 2'b11; step();
    check("ck_tag0", obs_tag0, 10); check("ck_tag1", obs_tag1, 11);
    req_valid = 2'b01; step();
    check("ck_tag2", obs_tag0, 12);
    prmiss = 1'b1; prmiss_ckpt = 2'd1; step();
    check("ck_pre_cnt", obs_cnt, 3);
    req_valid = 2'b01; step();
    check("ck_post_cnt", obs_cnt, 6); check("ck_post_tag", obs_tag0, 10);

    // take with same-cycle grants (not recorded), then prmiss with release and requests
    ckpt_take = 1'b1; ckpt_id = 2'd2; req_valid = 2'b11; step();
    check("take_grant0", obs_tag0, 11); check("take_grant1", obs_tag1, 12);
    req_valid = 2'b01; step();
    check("ck2_tag", obs_tag0, 20);
    prmiss = 1'b1; prmiss_ckpt = 2'd2; req_valid = 2'b11; rel(0, 3); step();
    check("prmiss_valid", obs_av, 0);
    req_valid = 2'b11; step();
    check("prmiss_cnt", obs_cnt, 4); check("prmiss_tag0", obs_tag0, 3);
    check("prmiss_tag1", obs_tag1, 20);

    // take and free on the same slot: take wins
    ckpt_take = 1'b1; ckpt_id = 2'd3; ckpt_free = 4'b1000; step();
    req_valid = 2'b01; step();
    check("tf_tag", obs_tag0, 21);
    prmiss = 1'b1; prmiss_ckpt = 2'd3; step();
    req_valid = 2'b01; step();
    check("tf_rec_tag", obs_tag0, 21); check("tf_rec_cnt", obs_cnt, 2);

    // stall suppresses everything
    stall = 1'b1; req_valid = 2'b11; step();
    check("stall_valid", obs_av, 0);
    req_valid = 2'b00; step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
